// File: rtl/audio_sample_conditioner.sv
// Box-filter decimator, midscale-to-signed converter and one-pole low-pass for the mixed POKEY sound word.
// Optional DC blocker on the output path is enabled by defining AUDIO_DCBLOCK_EN.
module audio_sample_conditioner #(
    parameter int DECIM    = 32,
    parameter int LP_SHIFT = 2,
    parameter int DC_SHIFT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  sample_in,
    input  logic        mute,
    output logic [15:0] audio_out,
    output logic        audio_valid
);

    localparam int CW = $clog2(DECIM);
    localparam int AW = 8 + CW;
    localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Reject parameter values the datapath widths are not sized for
    if (DECIM < 2 || DECIM > 256 || (DECIM & (DECIM - 1)) != 0) begin : g_bad_decim
        $error("DECIM must be a power of two in 2..256");
    end
    if (LP_SHIFT < 0 || LP_SHIFT > 7) begin : g_bad_lp
        $error("LP_SHIFT must be in 0..7");
    end
    if (DC_SHIFT < 4 || DC_SHIFT > 12) begin : g_bad_dc
        $error("DC_SHIFT must be in 4..12");
    end

    logic [CW-1:0]      cnt_r;
    logic [AW-1:0]      acc_r;
    logic [AW-1:0]      acc_sum_s;
    logic [7:0]         avg_r;
    logic [7:0]         avg_next_s;
    logic               dump_s;
    logic               v0_r;
    logic               v1_r;

    logic signed [15:0] pcm_s;
    logic signed [15:0] lp_r;
    logic signed [15:0] lp_next_s;
    logic signed [16:0] lp_diff_s;
    logic signed [16:0] lp_step_s;
    logic signed [16:0] lp_sum_s;

    logic [15:0]        y_s;

    // Stage 0 combinational: window sum including the current word, truncating average
    always_comb begin
        acc_sum_s  = acc_r + {{CW{1'b0}}, sample_in};
        avg_next_s = acc_sum_s[AW-1:CW];
        dump_s     = (cnt_r == CNT_LAST);
    end

    // Stage 0 registers: accumulate DECIM words, dump the average on the last one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CW{1'b0}};
            acc_r <= {AW{1'b0}};
            avg_r <= 8'h00;
            v0_r  <= 1'b0;
        end else if (dump_s) begin
            cnt_r <= {CW{1'b0}};
            acc_r <= {AW{1'b0}};
            avg_r <= avg_next_s;
            v0_r  <= 1'b1;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
            acc_r <= acc_sum_s;
            avg_r <= avg_r;
            v0_r  <= 1'b0;
        end
    end

    // Stage 1 combinational: flip the MSB to centre on midscale, then lp += (s - lp) >>> LP_SHIFT
    always_comb begin
        pcm_s     = {~avg_r[7], avg_r[6:0], 8'h00};
        lp_diff_s = {pcm_s[15], pcm_s} - {lp_r[15], lp_r};
        lp_step_s = lp_diff_s >>> LP_SHIFT;
        lp_sum_s  = {lp_r[15], lp_r} + lp_step_s;
        lp_next_s = lp_sum_s[15:0];
    end

    // Stage 1 registers: low-pass state advances once per decimated sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lp_r <= 16'sh0000;
            v1_r <= 1'b0;
        end else if (v0_r) begin
            lp_r <= lp_next_s;
            v1_r <= 1'b1;
        end else begin
            lp_r <= lp_r;
            v1_r <= 1'b0;
        end
    end

`ifdef AUDIO_DCBLOCK_EN
    logic signed [15:0] dc_r;
    logic signed [15:0] dc_next_s;
    logic signed [16:0] dc_diff_s;
    logic signed [16:0] dc_step_s;
    logic signed [16:0] dc_sum_s;

    // DC blocker: output uses the pre-update dc estimate, saturated to 16 bits
    always_comb begin
        dc_diff_s = {lp_r[15], lp_r} - {dc_r[15], dc_r};
        dc_step_s = dc_diff_s >>> DC_SHIFT;
        dc_sum_s  = {dc_r[15], dc_r} + dc_step_s;
        dc_next_s = dc_sum_s[15:0];
        if (dc_diff_s[16] != dc_diff_s[15]) begin
            if (dc_diff_s[16]) begin
                y_s = 16'h8000;
            end else begin
                y_s = 16'h7FFF;
            end
        end else begin
            y_s = dc_diff_s[15:0];
        end
    end

    // DC estimate tracks the low-pass output, independent of mute
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dc_r <= 16'sh0000;
        end else if (v1_r) begin
            dc_r <= dc_next_s;
        end else begin
            dc_r <= dc_r;
        end
    end
`else
    // Without the DC blocker the low-pass state is the output
    always_comb begin
        y_s = lp_r;
    end
`endif

    // Stage 2 registers: publish the sample with a one-cycle strobe; mute only zeroes the word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            audio_out   <= 16'h0000;
            audio_valid <= 1'b0;
        end else if (v1_r) begin
            audio_out   <= mute ? 16'h0000 : y_s;
            audio_valid <= 1'b1;
        end else begin
            audio_out   <= audio_out;
            audio_valid <= 1'b0;
        end
    end

endmodule
